// File: rtl/led_pwm_pkg.sv
// Shared widths and types for the LED PWM stage and its per-LED channels.
package led_pwm_pkg;

  localparam int PWM_W_DEF  = 4;
  localparam int PWM_PERIOD = 2 ** PWM_W_DEF;
  localparam int DUTY_W     = PWM_W_DEF + 1;

  typedef logic [DUTY_W-1:0] duty_t;

endpackage

// File: rtl/led_pwm_stage_if.sv
// Valid/ready pattern handshake between the LED counter and the PWM stage.
interface led_pwm_stage_if #(
  parameter int N_LEDS = 4
) ();

  logic              in_valid;
  logic [N_LEDS-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/led_pwm_channel.sv
// One LED channel: duty register updated at period boundaries and a registered PWM compare.
// LED_PWM_FADE_EN: an unlit channel halves its duty each boundary instead of dropping to zero.
module led_pwm_channel #(
  parameter int PWM_W   = 4,
  parameter int ON_DUTY = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             boundary,
  input  logic             lit,
  input  logic [PWM_W-1:0] pwm_cnt,
  output logic             led
);

  localparam int DW = PWM_W + 1;
  localparam logic [DW-1:0] ON_VAL   = DW'(ON_DUTY);
  localparam logic [DW-1:0] FULL_VAL = DW'(2 ** PWM_W);

  logic [DW-1:0] duty_q, duty_d;
  logic          led_q, led_d;

  always_comb begin
    duty_d = duty_q;
    if (boundary) begin
      if (lit) begin
        duty_d = ON_VAL;
      end else begin
`ifdef LED_PWM_FADE_EN
        duty_d = duty_q >> 1;
`else
        duty_d = '0;
`endif
      end
    end
    // Full-period duty must not drop out on the wrap cycle.
    led_d = (duty_q == FULL_VAL) | ({1'b0, pwm_cnt} < duty_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_q <= '0;
      led_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      led_q  <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/led_pwm_stage.sv
// LED PWM stage: buffers one pattern from the counter and applies it only at period boundaries.
// LED_PWM_FADE_EN selects exponential fade-out of released LEDs (implemented in led_pwm_channel).
module led_pwm_stage
  import led_pwm_pkg::*;
#(
  parameter int N_LEDS  = 4,
  parameter int PWM_W   = PWM_W_DEF,
  parameter int ON_DUTY = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  led_pwm_stage_if.slave    up,
  output logic [N_LEDS-1:0] led,
  output logic              period_tick
);

  localparam logic [PWM_W-1:0] CNT_LAST = '1;

  logic [PWM_W-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic              pending_q, pending_d;
  logic [N_LEDS-1:0] shadow_q, shadow_d;
  logic [N_LEDS-1:0] applied_q, applied_d;
  logic              boundary;
  logic              accept;

  always_comb begin
    boundary  = (pwm_cnt_q == CNT_LAST);
    accept    = up.in_valid && !pending_q;
    pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
    pending_d = pending_q;
    shadow_d  = shadow_q;
    applied_d = applied_q;
    if (boundary && pending_q) begin
      applied_d = shadow_q;
      pending_d = 1'b0;
    end
    // Ready is low whenever something is pending, so this never collides with the apply above.
    if (accept) begin
      shadow_d  = up.in_data;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      pending_q <= 1'b0;
      shadow_q  <= '0;
      applied_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
      applied_q <= applied_d;
    end
  end

  assign up.in_ready  = !pending_q;
  assign period_tick  = boundary;

  // Channels see the post-boundary applied value so the duty tracks the new pattern.
  for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
    led_pwm_channel #(
      .PWM_W   (PWM_W),
      .ON_DUTY (ON_DUTY)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .boundary (boundary),
      .lit      (applied_d[i]),
      .pwm_cnt  (pwm_cnt_q),
      .led      (led[i])
    );
  end

endmodule

// File: tb/tb_led_pwm_stage.sv
// Scoreboard bench for led_pwm_stage: a period-level model predicts each 16-cycle LED window.
module tb_led_pwm_stage;

  localparam int N     = 4;
  localparam int PER   = 16;
  localparam int ON_A  = 8;
  localparam int B_CHK = 60;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;
  logic [N-1:0] led_a, led_b;
  logic tick_a, tick_b;

  led_pwm_stage_if #(.N_LEDS(N)) bus_a ();
  led_pwm_stage_if #(.N_LEDS(N)) bus_b ();

  led_pwm_stage #(.N_LEDS(N), .PWM_W(4), .ON_DUTY(ON_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .up(bus_a), .led(led_a), .period_tick(tick_a)
  );

  led_pwm_stage #(.N_LEDS(N), .PWM_W(4), .ON_DUTY(16)) dut_b (
    .clk(clk), .rst_n(rst2_n), .up(bus_b), .led(led_b), .period_tick(tick_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               start;
    logic [PER*N-1:0] wave;
  } win_t;

  win_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  int           m_cnt = 0;
  int           m_duty[N];
  logic         m_pend = 1'b0;
  logic         m_valid = 1'b0;
  logic         m_after_rst = 1'b0;
  logic [N-1:0] m_shadow = '0;
  logic [N-1:0] m_applied = '0;
  logic [N-1:0] hist[32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: check this cycle's outputs, drive inputs, advance the period-level model.
  task automatic step(input logic r, input logic v, input logic [N-1:0] d);
    logic acc;
    logic [PER*N-1:0] w;
    @(negedge clk);
    if (m_valid) begin
      chk("in_ready", 64'(bus_a.in_ready), 64'(!m_pend));
      chk("period_tick", 64'(tick_a), 64'(m_cnt == PER - 1));
      if (m_after_rst) chk("led_after_reset", 64'(led_a), 64'(0));
    end
    if (cyc >= B_CHK) chk("led_full_on", 64'(led_b), 64'hF);
    rst_n          = r;
    rst2_n         = (cyc >= 3);
    bus_a.in_valid = v;
    bus_a.in_data  = d;
    if (!r) begin
      m_valid     = 1'b1;
      m_cnt       = 0;
      m_pend      = 1'b0;
      m_shadow    = '0;
      m_applied   = '0;
      m_after_rst = 1'b1;
      for (int i = 0; i < N; i++) m_duty[i] = 0;
      exp_q.delete();
      exp_q.push_back('{cyc + 1, '0});
    end else begin
      acc = v && !m_pend;
      if (m_cnt == PER - 1) begin
        if (m_pend) begin
          m_applied = m_shadow;
          m_pend    = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
          if (m_applied[i]) m_duty[i] = ON_A;
          else begin
`ifdef LED_PWM_FADE_EN
            m_duty[i] = m_duty[i] / 2;
`else
            m_duty[i] = 0;
`endif
          end
        end
        w = '0;
        for (int j = 0; j < PER; j++)
          for (int i = 0; i < N; i++)
            w[j*N+i] = (m_duty[i] == PER) || (j < m_duty[i]);
        exp_q.push_back('{cyc + 2, w});
      end
      if (acc) begin
        m_shadow = d;
        m_pend   = 1'b1;
      end
      m_cnt       = (m_cnt + 1) % PER;
      m_after_rst = 1'b0;
    end
    cyc++;
  endtask

  task automatic idle_until(input int c, input bit need_free);
    int guard;
    guard = 0;
    while (!(m_cnt == c && (!need_free || !m_pend)) && guard < 200) begin
      step(1'b1, 1'b0, '0);
      guard++;
    end
    if (guard >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout cyc=%0d got=cnt%0d expected=cnt%0d", cyc, m_cnt, c);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, '0);
  endtask

  always @(posedge clk) begin : monitor
    win_t e;
    logic [PER*N-1:0] act;
    #1;
    hist[cyc % 32] = led_a;
    if (exp_q.size() > 0 && exp_q[0].start + PER - 1 <= cyc) begin
      e = exp_q.pop_front();
      act = '0;
      for (int j = 0; j < PER; j++) act[j*N +: N] = hist[(e.start + j) % 32];
      chk("led_window", act, e.wave);
    end
  end

  initial begin
    logic took;
    int guard;
    bus_a.in_valid = 1'b0;
    bus_a.in_data  = '0;
    bus_b.in_valid = 1'b1;
    bus_b.in_data  = 4'hF;
    for (int i = 0; i < N; i++) m_duty[i] = 0;

    // Reset held with a pattern offered; it is taken on the first released cycle.
    repeat (3) step(1'b0, 1'b1, 4'hF);
    step(1'b1, 1'b1, 4'hF);
    idle(40);

    // Pattern accepted mid-period at count 5.
    idle_until(5, 1'b1);
    step(1'b1, 1'b1, 4'b0101);
    idle(48);

    // Pattern held while the buffer is full.
    idle_until(2, 1'b1);
    step(1'b1, 1'b1, 4'b0011);
    guard = 0;
    do begin
      took = !m_pend;
      step(1'b1, 1'b1, 4'b1000);
      guard++;
    end while (!took && guard < 100);
    if (!took) begin
      vectors++;
      miscompares++;
      $display("FAIL hold_accept cyc=%0d got=pending expected=accepted", cyc);
    end
    idle(48);

    // Single LED on, then released (fade or hard off).
    idle_until(7, 1'b1);
    step(1'b1, 1'b1, 4'b0001);
    idle(40);
    idle_until(7, 1'b1);
    step(1'b1, 1'b1, 4'b0000);
    idle(8 * PER);

    for (int k = 0; k < 300; k++)
      step(1'b1, ($urandom_range(0, 3) == 0), N'($urandom));

    // Reset mid-period with a pattern pending.
    idle_until(3, 1'b1);
    step(1'b1, 1'b1, 4'hA);
    idle_until(9, 1'b0);
    step(1'b0, 1'b0, '0);
    idle(48);

    for (int k = 0; k < 80; k++)
      step(1'b1, ($urandom_range(0, 2) == 0), N'($urandom));
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
